// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the CPU data-memory bus responder.
// Also used by the CPU top for default bus widths and RNW encoding.
package sram_bus_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 7;

    localparam logic RNW_READ  = 1'b1;
    localparam logic RNW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_e;

    // Wait counter width; never narrower than one bit, even with zero wait states.
    function automatic int cnt_width(input int ws);
        return (ws > 0) ? $clog2(ws + 1) : 1;
    endfunction

endpackage

// File: rtl/sram_bus_if.sv
// Data-memory bus between the CPU memory stage (master) and the responder (slave).
// Split WrData/RdData; the top level builds the shared bus using DataDrive.
interface sram_bus_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] AdxBus;
    logic [DATA_W-1:0] WrData;
    logic              OE;
    logic              RNW;
    logic [DATA_W-1:0] RdData;
    logic              DataDrive;
    logic              Ready;
    logic              Busy;

    modport master (
        output AdxBus, WrData, OE, RNW,
        input  RdData, DataDrive, Ready, Busy
    );

    modport slave (
        input  AdxBus, WrData, OE, RNW,
        output RdData, DataDrive, Ready, Busy
    );
endinterface

// File: rtl/sram_array.sv
// DEPTH x DATA_W storage with synchronous write and registered read.
// Deliberately has no reset: contents survive a bus reset.
module sram_array #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 7
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sram_bus_responder.sv
// Memory-side responder: accepts one OE-rising-edge request at a time,
// inserts WAIT_STATES cycles, then pulses Ready for one cycle.
module sram_bus_responder
    import sram_bus_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_STATES = 2
) (
    input  logic     Clock,
    input  logic     Reset,
    sram_bus_if.slave bus
);
    localparam int CNT_W = cnt_width(WAIT_STATES);

    state_e            state_q, state_d;
    logic              oe_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rnw_q, rnw_d;
    logic              rd_vld_q, rd_vld_d;

    logic              request;
    logic              commit;
    logic              mem_we, mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // Only the rising edge of OE starts an access; holding OE high does not retrigger.
    assign request = bus.OE & ~oe_q;
    assign commit  = (state_q == ACCESS) && bus.OE && (cnt_q == '0);

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            oe_q     <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rnw_q    <= RNW_WRITE;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            oe_q     <= bus.OE;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rnw_q    <= rnw_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rnw_d   = rnw_q;
        unique case (state_q)
            IDLE: begin
                if (request) begin
                    addr_d  = bus.AdxBus;
                    wdata_d = bus.WrData;
                    rnw_d   = bus.RNW;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.OE)            state_d = IDLE;
                else if (cnt_q == '0)   state_d = RESPOND;
                else                    cnt_d   = cnt_q - 1'b1;
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_we   = commit && (rnw_q == RNW_WRITE);
        mem_re   = commit && (rnw_q == RNW_READ);
        rd_vld_d = rd_vld_q | mem_re;
    end

    sram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (Clock),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    // The array's read register has no reset, so RdData is forced to zero
    // until the first read after reset has landed; afterwards it simply holds.
    assign bus.RdData    = rd_vld_q ? mem_rdata : '0;
    assign bus.Ready     = (state_q == RESPOND);
    assign bus.DataDrive = (state_q == RESPOND) && (rnw_q == RNW_READ);
    assign bus.Busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sram_bus_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) driven by directed
// and random transactions, checked against an array model of memory.
module tb_sram_bus_responder;
    import sram_bus_pkg::*;

    typedef struct {
        logic        rnw;
        logic [63:0] data;
    } exp_t;

    logic        clk, rst;
    logic [6:0]  adx;
    logic [63:0] wd;
    logic        rnw, oe;
    int          sel;

    int total = 0;
    int bad   = 0;

    exp_t        q [2][$];
    logic [63:0] mem_m [2][128];
    int          pool [7] = '{0, 3, 5, 9, 17, 64, 127};

    logic        rdy [2], bsy [2], dd [2];
    logic [63:0] rdd [2];

    sram_bus_if #(.DATA_W(64), .ADDR_W(7)) b0 ();
    sram_bus_if #(.DATA_W(64), .ADDR_W(7)) b1 ();

    assign b0.AdxBus = adx;  assign b1.AdxBus = adx;
    assign b0.WrData = wd;   assign b1.WrData = wd;
    assign b0.RNW    = rnw;  assign b1.RNW    = rnw;
    assign b0.OE     = oe && (sel == 0);
    assign b1.OE     = oe && (sel == 1);

    assign rdy[0] = b0.Ready;     assign rdy[1] = b1.Ready;
    assign bsy[0] = b0.Busy;      assign bsy[1] = b1.Busy;
    assign dd[0]  = b0.DataDrive; assign dd[1]  = b1.DataDrive;
    assign rdd[0] = b0.RdData;    assign rdd[1] = b1.RdData;

    sram_bus_responder #(.DATA_W(64), .ADDR_W(7), .WAIT_STATES(2)) dut0 (
        .Clock (clk), .Reset (rst), .bus (b0)
    );
    sram_bus_responder #(.DATA_W(64), .ADDR_W(7), .WAIT_STATES(0)) dut1 (
        .Clock (clk), .Reset (rst), .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int ws(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    // Monitor: every Ready pulse must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rdy[s] === 1'b1) begin
                if (q[s].size() == 0) begin
                    chk("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    mon_e = q[s].pop_front();
                    chk("resp_drive", {63'd0, dd[s]}, {63'd0, mon_e.rnw});
                    chk("resp_busy", {63'd0, bsy[s]}, 64'd1);
                    if (mon_e.rnw) chk("rd_data", rdd[s], mon_e.data);
                end
            end
        end
    end

    // One complete transaction; hold keeps OE high for 10 cycles after Ready.
    task automatic txn(input int s, input logic r, input logic [6:0] a,
                       input logic [63:0] d, input bit hold);
        exp_t e;
        int   n;
        bit   got;
        @(negedge clk);
        sel = s; adx = a; wd = d; rnw = r; oe = 1'b1;
        e.rnw = r;
        e.data = r ? mem_m[s][a] : d;
        if (!r) mem_m[s][a] = d;
        q[s].push_back(e);
        got = 1'b0;
        n = 0;
        for (int i = 0; i < ws(s) + 6; i++) begin
            @(negedge clk);
            n++;
            if (rdy[s] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (got) chk("latency", 64'(n), 64'(ws(s) + 2));
        else     chk("ready_timeout", 64'd0, 64'd1);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("hold_no_ready", {63'd0, rdy[s]}, 64'd0);
                chk("hold_busy", {63'd0, bsy[s]}, 64'd0);
            end
        end
        oe = 1'b0;
    endtask

    // Write started then OE dropped after acceptance: must never complete.
    task automatic abort_wr(input int s, input logic [6:0] a, input logic [63:0] d);
        @(negedge clk);
        sel = s; adx = a; wd = d; rnw = RNW_WRITE; oe = 1'b1;
        @(negedge clk);
        chk("abort_busy_on", {63'd0, bsy[s]}, 64'd1);
        oe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_ready", {63'd0, rdy[s]}, 64'd0);
            chk("abort_busy_off", {63'd0, bsy[s]}, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; oe = 1'b0; sel = 0; adx = '0; wd = '0; rnw = RNW_READ;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", {63'd0, rdy[s]}, 64'd0);
            chk("rst_busy", {63'd0, bsy[s]}, 64'd0);
            chk("rst_drive", {63'd0, dd[s]}, 64'd0);
            chk("rst_rddata", rdd[s], 64'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 2; s++)
            foreach (pool[i]) txn(s, RNW_WRITE, 7'(pool[i]), 64'd0, 1'b0);

        // Write then read with two wait states
        txn(0, RNW_WRITE, 7'd5, 64'hDEAD_BEEF_0000_0001, 1'b0);
        txn(0, RNW_READ,  7'd5, 64'd0, 1'b0);

        // Asynchronous reset during the wait of a write
        @(negedge clk);
        sel = 0; adx = 7'd3; wd = 64'hFF; rnw = RNW_WRITE; oe = 1'b1;
        @(negedge clk);
        chk("pre_rst_busy", {63'd0, bsy[0]}, 64'd1);
        chk("pre_rst_rddata", rdd[0], 64'hDEAD_BEEF_0000_0001);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", {63'd0, rdy[0]}, 64'd0);
        chk("async_rst_busy", {63'd0, bsy[0]}, 64'd0);
        chk("async_rst_drive", {63'd0, dd[0]}, 64'd0);
        chk("async_rst_rddata", rdd[0], 64'd0);
        @(negedge clk);
        oe = 1'b0; rst = 1'b0;
        txn(0, RNW_READ, 7'd3, 64'd0, 1'b0);

        // Abort then confirm the array kept its old value
        abort_wr(0, 7'd9, 64'h1234);
        txn(0, RNW_READ, 7'd9, 64'd0, 1'b0);

        // OE held high after completion
        txn(0, RNW_READ, 7'd5, 64'd0, 1'b1);

        // Back-to-back with zero wait states
        txn(1, RNW_WRITE, 7'd0, 64'hA, 1'b0);
        txn(1, RNW_READ,  7'd0, 64'd0, 1'b0);

        // Top address
        txn(0, RNW_WRITE, 7'd127, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        txn(0, RNW_READ,  7'd127, 64'd0, 1'b0);
        txn(0, RNW_READ,  7'd0,   64'd0, 1'b0);

        // Random mix over a pre-written address pool on both responders
        for (int i = 0; i < 80; i++) begin
            int s, op;
            logic [6:0]  a;
            logic [63:0] d;
            s  = int'($urandom_range(1, 0));
            op = int'($urandom_range(5, 0));
            a  = 7'(pool[$urandom_range(6, 0)]);
            d  = {$urandom, $urandom};
            if (op == 0)      abort_wr(s, a, d);
            else if (op < 3)  txn(s, RNW_WRITE, a, d, 1'b0);
            else              txn(s, RNW_READ, a, 64'd0, 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("queue_drain", 64'(q[0].size() + q[1].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_bus_responder.md
Name: sram_bus_responder

Overview:
- Memory-side responder for the CPU's data-memory bus: address, write data, OE and RNW in; read data and a Ready strobe out.
- Holds a DEPTH-word storage array and inserts a programmable number of wait states before each response.
- Sits between the pipelined CPU's memory stage and data storage, so the CPU's stall/handshake logic can be exercised against non-zero memory latency.
- Replaces the internal tri-state DataBus with split WrData/RdData plus a DataDrive enable; the top level builds the shared bus from these.

Parameters:
- DATA_W, 64, width of one memory word and of the data buses.
- ADDR_W, 7, word-address width; DEPTH = 2**ADDR_W words.
- WAIT_STATES, 2, extra cycles between request acceptance and Ready (0 allowed).

Ports:
- Clock  input  1  single system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- AdxBus  input  ADDR_W  word address of the request.
- WrData  input  DATA_W  write data, sampled at acceptance.
- OE  input  1  request strobe; held high by the initiator for the whole transaction.
- RNW  input  1  1 = read, 0 = write; sampled at acceptance.
- RdData  output  DATA_W  registered read data, valid while Ready=1 on a read.
- DataDrive  output  1  high while the responder is driving RdData onto the shared bus.
- Ready  output  1  one-cycle completion strobe.
- Busy  output  1  high from acceptance until Ready drops.

Behaviour:
- Reset (async, any state): state=IDLE, Ready=0, DataDrive=0, Busy=0, RdData=0, wait counter=0, OE history register=0.
- Array contents are not cleared by Reset. Any transaction in flight is discarded, including an uncommitted write.
- Registered history oe_q samples OE every edge. request = OE & ~oe_q (rising edge only).
- OE must return low for at least one cycle between transactions. Holding OE high after Ready never starts a second access.
- States: IDLE, ACCESS, RESPOND.
- IDLE:
  - On an edge with request=1: latch AdxBus, WrData and RNW, load cnt=WAIT_STATES, go to ACCESS. Busy=1 from that edge.
  - Otherwise stay in IDLE.
- ACCESS:
  - If OE=0 at an edge: abort to IDLE. No write, no Ready, Busy=0.
  - Else if cnt==0: go to RESPOND.
    - On a write, mem[addr] <= wdata at this same edge.
    - On a read, RdData <= mem[addr] at this same edge, observing any write committed on an earlier edge.
  - Else cnt <= cnt-1.
- RESPOND:
  - Ready=1 and Busy=1 for exactly this one cycle. DataDrive=1 only if the latched RNW=1.
  - Next edge goes to IDLE unconditionally. Ready, DataDrive and Busy drop.
  - OE falling during RESPOND has no effect.
- Latency: with acceptance at edge k, Ready is high in the cycle following edge k+1+WAIT_STATES.
  - WAIT_STATES=0 gives Ready after edge k+1.
  - The earliest next acceptance is edge k+3+WAIT_STATES (OE low one cycle, then high).
- RdData holds its last value outside RESPOND. It is not cleared on writes or aborts.
- Addressing: AdxBus indexes the array directly; no out-of-range case exists. The counter width is clog2(WAIT_STATES+1), minimum 1.
- Only one outstanding transaction is supported; there is no queueing.

Decomposition:
- Package sram_bus_pkg holds:
  - the state enum (IDLE, ACCESS, RESPOND);
  - default DATA_W/ADDR_W constants shared with the CPU top;
  - the RNW encoding constants RNW_READ=1 and RNW_WRITE=0.
- Sub-module sram_array holds the storage: DEPTH x DATA_W, synchronous write enable, synchronous registered read, no reset.
- The FSM, counter, edge detect and output registers stay in sram_bus_responder.

Test Plan:
- Write then read (WAIT_STATES=2):
  - Write 64'hDEAD_BEEF_0000_0001 to addr 5, OE accepted at edge 0 → Ready in cycle after edge 3, DataDrive=0.
  - Drop OE, then read addr 5 → RdData=64'hDEAD_BEEF_0000_0001 with Ready=1 and DataDrive=1 for one cycle.
- Abort: start a write of 64'h1234 to addr 9, drop OE at edge 1 before Ready.
  - Required: Ready never asserts and Busy clears.
  - A subsequent read of addr 9 returns the prior value (pre-written 64'h0).
- OE held high: keep OE=1 for 10 cycles after a read completes.
  - Required: exactly one Ready pulse; Busy=0 after RESPOND; no second access.
- Back-to-back with WAIT_STATES=0:
  - Write 64'hA to addr 0, OE low one cycle, then read addr 0.
  - Required: Ready one cycle after each acceptance edge; read returns 64'hA.
- Reset mid-operation: assert Reset asynchronously during ACCESS of a write of 64'hFF to addr 3.
  - Required: Ready, Busy, DataDrive and RdData go to 0 immediately, without waiting for a clock edge.
  - After release, a read of addr 3 returns the pre-reset contents, not 64'hFF.
- Boundary address: write and read addr 127 (ADDR_W=7) with 64'hFFFF_FFFF_FFFF_FFFF → data returned intact; addr 0 unaffected.
